gpio_pad_ctrl: RTL

Core-side GPIO controller sitting inside `chip_core` at the far end of the pad-ring interface. It owns every pad control signal that the top level routes to the I/O cells: output data, output enable, drive strength, slew, input enable, pull-up and pull-down. It synchronizes pad inputs into the core clock domain and exposes everything through a simple valid/ready register port. Optionally it latches input edges and raises an interrupt.

---
 rtl/gpio_pad_pkg.sv | 23 ++
 rtl/gpio_sync_edge.sv | 35 +++
 rtl/gpio_pad_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: register map, register-index enum and reset constants for gpio_pad_ctrl.
package gpio_pad_pkg;
    typedef enum logic [3:0] {
        REG_OUT, REG_OE, REG_IE, REG_PU, REG_PD, REG_CS, REG_SL,
        REG_BIDIR_IN, REG_INPUT_IN, REG_INPUT_PU, REG_INPUT_PD,
        REG_RISE_EN, REG_FALL_EN, REG_STATUS
    } gpio_reg_e;
    localparam logic [3:0] GPIO_ADDR_OUT      = REG_OUT;
    localparam logic [3:0] GPIO_ADDR_OE       = REG_OE;
    localparam logic [3:0] GPIO_ADDR_IE       = REG_IE;
    localparam logic [3:0] GPIO_ADDR_PU       = REG_PU;
    localparam logic [3:0] GPIO_ADDR_PD       = REG_PD;
    localparam logic [3:0] GPIO_ADDR_CS       = REG_CS;
    localparam logic [3:0] GPIO_ADDR_SL       = REG_SL;
    localparam logic [3:0] GPIO_ADDR_BIDIR_IN = REG_BIDIR_IN;
    localparam logic [3:0] GPIO_ADDR_INPUT_IN = REG_INPUT_IN;
    localparam logic [3:0] GPIO_ADDR_INPUT_PU = REG_INPUT_PU;
    localparam logic [3:0] GPIO_ADDR_INPUT_PD = REG_INPUT_PD;
    localparam logic [3:0] GPIO_ADDR_RISE_EN  = REG_RISE_EN;
    localparam logic [3:0] GPIO_ADDR_FALL_EN  = REG_FALL_EN;
    localparam logic [3:0] GPIO_ADDR_STATUS   = REG_STATUS;
    localparam logic [31:0] GPIO_IE_RESET = 32'hFFFF_FFFF;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop input synchronizer with an optional history flop for edge detection.
module gpio_sync_edge #(
    parameter int W    = 1,
    parameter bit HIST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic [W-1:0] rise_en,
    input  logic [W-1:0] fall_en,
    output logic [W-1:0] q,
    output logic [W-1:0] edge_o
);
    logic [W-1:0] s1_q, s2_q, s3_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    // Without history the stage-2 value is its own history, so no edges can ever fire.
    if (HIST) begin : g_hist
        always_ff @(posedge clk or posedge rst) begin
            if (rst) s3_q <= '0;
            else     s3_q <= s2_q;
        end
    end else begin : g_nohist
        assign s3_q = s2_q;
    end
    assign q      = s2_q;
    assign edge_o = (s2_q & ~s3_q & rise_en) | (~s2_q & s3_q & fall_en);
endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: register-mapped GPIO pad controller with input synchronizers.
// Edge capture, STATUS and irq are built only when GPIO_EDGE_IRQ_EN is defined.
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int NUM_INPUT_PADS = 4,
    parameter int NUM_BIDIR_PADS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [3:0]                req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    input  logic [NUM_INPUT_PADS-1:0] input_in,
    output logic [NUM_INPUT_PADS-1:0] input_pu,
    output logic [NUM_INPUT_PADS-1:0] input_pd,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
    output logic [NUM_BIDIR_PADS-1:0] bidir_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic                      irq
);
    localparam int NI = NUM_INPUT_PADS;
    localparam int NB = NUM_BIDIR_PADS;
    localparam int NS = NB + NI;
    logic [NB-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d, pu_q, pu_d, pd_q, pd_d, cs_q, cs_d, sl_q, sl_d;
    logic [NI-1:0] ipu_q, ipu_d, ipd_q, ipd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d, rdata;
    logic [63:0]   wd;
    logic          acc, wr;
    logic [NB-1:0] bi_sync, bi_edge;
    logic [NI-1:0] in_sync, in_edge;
    logic [NS-1:0] rise_en_q, fall_en_q, status_q;
`ifdef GPIO_EDGE_IRQ_EN
    localparam bit HIST = 1'b1;
    logic [NS-1:0] rise_en_d, fall_en_d, status_d;
    // A new edge is OR-ed in after the W1C clear so a coincident set wins.
    always_comb begin
        rise_en_d = (wr && req_addr == GPIO_ADDR_RISE_EN) ? wd[NS-1:0] : rise_en_q;
        fall_en_d = (wr && req_addr == GPIO_ADDR_FALL_EN) ? wd[NS-1:0] : fall_en_q;
        status_d  = (status_q & ~((wr && req_addr == GPIO_ADDR_STATUS) ? wd[NS-1:0] : '0))
                    | {in_edge, bi_edge};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
        end
    end
`else
    localparam bit HIST = 1'b0;
    assign rise_en_q = '0;
    assign fall_en_q = '0;
    assign status_q  = '0;
`endif
    gpio_sync_edge #(.W(NB), .HIST(HIST)) u_bidir_sync (
        .clk(clk), .rst(rst), .d(bidir_in), .rise_en(rise_en_q[NB-1:0]),
        .fall_en(fall_en_q[NB-1:0]), .q(bi_sync), .edge_o(bi_edge)
    );
    gpio_sync_edge #(.W(NI), .HIST(HIST)) u_input_sync (
        .clk(clk), .rst(rst), .d(input_in), .rise_en(rise_en_q[NS-1:NB]),
        .fall_en(fall_en_q[NS-1:NB]), .q(in_sync), .edge_o(in_edge)
    );
    assign acc       = req_valid & req_ready;
    assign wr        = acc & req_write;
    assign wd        = 64'(req_wdata);
    assign req_ready = ~rsp_valid_q | rsp_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign irq       = |status_q;
    assign bidir_out = out_q;
    assign bidir_oe  = oe_q;
    assign bidir_ie  = ie_q;
    assign bidir_cs  = cs_q;
    assign bidir_sl  = sl_q;
    assign bidir_pu  = pu_q;
    assign bidir_pd  = pd_q & ~pu_q;
    assign input_pu  = ipu_q;
    assign input_pd  = ipd_q & ~ipu_q;
    always_comb begin
        case (req_addr)
            GPIO_ADDR_OUT:      rdata = 32'(out_q);
            GPIO_ADDR_OE:       rdata = 32'(oe_q);
            GPIO_ADDR_IE:       rdata = 32'(ie_q);
            GPIO_ADDR_PU:       rdata = 32'(pu_q);
            GPIO_ADDR_PD:       rdata = 32'(pd_q);
            GPIO_ADDR_CS:       rdata = 32'(cs_q);
            GPIO_ADDR_SL:       rdata = 32'(sl_q);
            GPIO_ADDR_BIDIR_IN: rdata = 32'(bi_sync);
            GPIO_ADDR_INPUT_IN: rdata = 32'(in_sync);
            GPIO_ADDR_INPUT_PU: rdata = 32'(ipu_q);
            GPIO_ADDR_INPUT_PD: rdata = 32'(ipd_q);
            GPIO_ADDR_RISE_EN:  rdata = 32'(rise_en_q);
            GPIO_ADDR_FALL_EN:  rdata = 32'(fall_en_q);
            GPIO_ADDR_STATUS:   rdata = 32'(status_q);
            default:            rdata = '0;
        endcase
    end
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        ie_d  = ie_q;
        pu_d  = pu_q;
        pd_d  = pd_q;
        cs_d  = cs_q;
        sl_d  = sl_q;
        ipu_d = ipu_q;
        ipd_d = ipd_q;
        if (wr) begin
            case (req_addr)
                GPIO_ADDR_OUT:      out_d = wd[NB-1:0];
                GPIO_ADDR_OE:       oe_d  = wd[NB-1:0];
                GPIO_ADDR_IE:       ie_d  = wd[NB-1:0];
                GPIO_ADDR_PU:       pu_d  = wd[NB-1:0];
                GPIO_ADDR_PD:       pd_d  = wd[NB-1:0];
                GPIO_ADDR_CS:       cs_d  = wd[NB-1:0];
                GPIO_ADDR_SL:       sl_d  = wd[NB-1:0];
                GPIO_ADDR_INPUT_PU: ipu_d = wd[NI-1:0];
                GPIO_ADDR_INPUT_PD: ipd_d = wd[NI-1:0];
                default: ;
            endcase
        end
        rsp_valid_d = acc | (rsp_valid_q & ~rsp_ready);
        rsp_rdata_d = acc ? (req_write ? '0 : rdata) : rsp_rdata_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            oe_q        <= '0;
            ie_q        <= GPIO_IE_RESET[NB-1:0];
            pu_q        <= '0;
            pd_q        <= '0;
            cs_q        <= '0;
            sl_q        <= '0;
            ipu_q       <= '0;
            ipd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            out_q       <= out_d;
            oe_q        <= oe_d;
            ie_q        <= ie_d;
            pu_q        <= pu_d;
            pd_q        <= pd_d;
            cs_q        <= cs_d;
            sl_q        <= sl_d;
            ipu_q       <= ipu_d;
            ipd_q       <= ipd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end
endmodule
